// File: rtl/rotary_pkg.sv
// Shared types and constants for the rotary quadrature decoder.
// Optional saturation of the position count is enabled with ROTARY_SAT_EN (see rotary_quad_decoder).
package rotary_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

    typedef enum logic [1:0] {
        TR_NONE,
        TR_CW,
        TR_CCW,
        TR_ILLEGAL
    } trans_t;

    // Next phase when turning clockwise: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] cw_next(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_transition_decode.sv
// Combinational classifier: maps a (previous, current) {A,B} phase pair
// to no-change, clockwise, counter-clockwise or illegal (both bits changed).
module quad_transition_decode
    import rotary_pkg::*;
(
    input  logic [1:0] i_prev,
    input  logic [1:0] i_cur,
    output trans_t     o_class
);

    always_comb begin
        o_class = TR_NONE;
        if (i_prev == i_cur) begin
            o_class = TR_NONE;
        end else if (i_cur == cw_next(i_prev)) begin
            o_class = TR_CW;
        end else if (i_prev == cw_next(i_cur)) begin
            o_class = TR_CCW;
        end else begin
            o_class = TR_ILLEGAL;
        end
    end

endmodule

// File: rtl/rotary_quad_decoder.sv
// Quadrature decoder: step/dir pulses, WIDTH-bit position count and illegal-transition flag.
// Define ROTARY_SAT_EN to make the count saturate at its limits instead of wrapping.
//
// state    | meaning
// ST_INIT  | first edge after reset: capture {A,B} as the reference phase, no events
// ST_TRACK | classify every edge against the previous phase and count movements
module rotary_quad_decoder
    import rotary_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DETENT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clear,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             err
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic [1:0]       r_prev;
    logic             r_step;
    logic             r_dir;
    logic [WIDTH-1:0] r_count;
    logic             r_err;

    state_t           w_state_nxt;
    logic [1:0]       w_prev_nxt;
    logic             w_step_nxt;
    logic             w_dir_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_err_nxt;

    logic [1:0]       w_cur;
    trans_t           w_class;
    logic             w_valid;
    logic             w_counted;
    logic [WIDTH-1:0] w_count_up;
    logic [WIDTH-1:0] w_count_dn;

    assign w_cur = {a_in, b_in};

    quad_transition_decode u_decode (
        .i_prev  (r_prev),
        .i_cur   (w_cur),
        .o_class (w_class)
    );

    // In detent mode only the transition that lands on the rest phase 00 counts.
    assign w_valid   = (w_class == TR_CW) || (w_class == TR_CCW);
    assign w_counted = w_valid && ((DETENT == 0) || (w_cur == PH_00));

`ifdef ROTARY_SAT_EN
    assign w_count_up = (r_count == CNT_MAX) ? r_count : r_count + CNT_ONE;
    assign w_count_dn = (r_count == '0)      ? r_count : r_count - CNT_ONE;
`else
    assign w_count_up = r_count + CNT_ONE;
    assign w_count_dn = r_count - CNT_ONE;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = w_cur;
        w_step_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_dir_nxt   = r_dir;
        w_count_nxt = r_count;

        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_TRACK;
            end
            ST_TRACK: begin
                if (w_class == TR_ILLEGAL) begin
                    w_err_nxt = 1'b1;
                end else if (w_counted) begin
                    w_step_nxt = 1'b1;
                    if (w_class == TR_CW) begin
                        w_dir_nxt   = DIR_CW;
                        w_count_nxt = w_count_up;
                    end else begin
                        w_dir_nxt   = DIR_CCW;
                        w_count_nxt = w_count_dn;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase

        // Clear overrides any movement on the same edge; step/dir still report it.
        if (clear) begin
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
            r_prev  <= PH_00;
            r_step  <= 1'b0;
            r_dir   <= DIR_CCW;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= w_prev_nxt;
            r_step  <= w_step_nxt;
            r_dir   <= w_dir_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign step  = r_step;
    assign dir   = r_dir;
    assign count = r_count;
    assign err   = r_err;

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Self-checking bench: one DETENT=1 and one DETENT=0 decoder share the same A/B stimulus;
// a behavioural model pushes expected outputs to a scoreboard that is popped after each edge.
module tb_rotary_quad_decoder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         a_in;
    logic         b_in;
    logic         clear;

    logic         step_d, dir_d, err_d;
    logic [W-1:0] count_d;
    logic         step_x, dir_x, err_x;
    logic [W-1:0] count_x;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rotary_quad_decoder #(.WIDTH(W), .DETENT(1)) u_dut_det (
        .clk     (clk),
        .reset_n (reset_n),
        .a_in    (a_in),
        .b_in    (b_in),
        .clear   (clear),
        .step    (step_d),
        .dir     (dir_d),
        .count   (count_d),
        .err     (err_d)
    );

    rotary_quad_decoder #(.WIDTH(W), .DETENT(0)) u_dut_x4 (
        .clk     (clk),
        .reset_n (reset_n),
        .a_in    (a_in),
        .b_in    (b_in),
        .clear   (clear),
        .step    (step_x),
        .dir     (dir_x),
        .count   (count_x),
        .err     (err_x)
    );

    typedef struct {
        int           id;     // 1 = detent instance, 0 = x4 instance
        logic         step;
        logic         dir;
        logic         err;
        logic [W-1:0] count;
    } exp_t;

    exp_t         sb[$];
    logic [1:0]   m_prev[2];
    logic [W-1:0] m_count[2];
    logic         m_dir[2];
    bit           m_init[2];

    // Position of a phase along the clockwise cycle 00,10,11,01.
    function automatic int ph_idx(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_prev[d]  = 2'b00;
            m_count[d] = '0;
            m_dir[d]   = 1'b0;
            m_init[d]  = 1'b1;
        end
        sb.delete();
    endtask

    task automatic model_edge(input int d, input logic [1:0] cur, input logic clr);
        exp_t e;
        int   diff;
        e.id   = d;
        e.step = 1'b0;
        e.err  = 1'b0;
        if (m_init[d]) begin
            m_init[d] = 1'b0;
        end else begin
            diff = (ph_idx(cur) - ph_idx(m_prev[d])) & 3;
            if (diff == 2) begin
                e.err = 1'b1;
            end else if (diff != 0 && (d == 0 || cur == 2'b00)) begin
                e.step   = 1'b1;
                m_dir[d] = (diff == 1);
                if (diff == 1) begin
`ifdef ROTARY_SAT_EN
                    if (m_count[d] != 8'hFF) m_count[d] = m_count[d] + 8'd1;
`else
                    m_count[d] = m_count[d] + 8'd1;
`endif
                end else begin
`ifdef ROTARY_SAT_EN
                    if (m_count[d] != 8'h00) m_count[d] = m_count[d] - 8'd1;
`else
                    m_count[d] = m_count[d] - 8'd1;
`endif
                end
            end
        end
        m_prev[d] = cur;
        if (clr) m_count[d] = '0;
        e.dir   = m_dir[d];
        e.count = m_count[d];
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " det.step"},  32'(step_d),  32'd0);
        check({tag, " det.dir"},   32'(dir_d),   32'd0);
        check({tag, " det.count"}, 32'(count_d), 32'd0);
        check({tag, " det.err"},   32'(err_d),   32'd0);
        check({tag, " x4.step"},   32'(step_x),  32'd0);
        check({tag, " x4.dir"},    32'(dir_x),   32'd0);
        check({tag, " x4.count"},  32'(count_x), 32'd0);
        check({tag, " x4.err"},    32'(err_x),   32'd0);
    endtask

    // Drive one cycle of inputs at the falling edge, then score after the rising edge.
    task automatic apply(input string tag, input logic a, input logic b, input logic clr);
        exp_t e;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        clear = clr;
        model_edge(1, {a, b}, clr);
        model_edge(0, {a, b}, clr);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.id == 1) begin
                check({tag, " det.step"},  32'(step_d),  32'(e.step));
                check({tag, " det.dir"},   32'(dir_d),   32'(e.dir));
                check({tag, " det.count"}, 32'(count_d), 32'(e.count));
                check({tag, " det.err"},   32'(err_d),   32'(e.err));
            end else begin
                check({tag, " x4.step"},   32'(step_x),  32'(e.step));
                check({tag, " x4.dir"},    32'(dir_x),   32'(e.dir));
                check({tag, " x4.count"},  32'(count_x), 32'(e.count));
                check({tag, " x4.err"},    32'(err_x),   32'(e.err));
            end
        end
    endtask

    task automatic walk(input string tag, input logic cw, input int hold);
        logic [1:0] seq_cw[4];
        logic [1:0] seq_ccw[4];
        logic [1:0] ph;
        seq_cw  = '{2'b10, 2'b11, 2'b01, 2'b00};
        seq_ccw = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            ph = cw ? seq_cw[i] : seq_ccw[i];
            for (int h = 0; h < hold; h++) apply(tag, ph[1], ph[0], 1'b0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_in    = 1'b1;
        b_in    = 1'b1;
        clear   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;

        // Encoder resting at 11 through reset release: no spurious movement.
        repeat (5) apply("rest11", 1'b1, 1'b1, 1'b0);
        apply("to01", 1'b0, 1'b1, 1'b0);
        apply("to00", 1'b0, 1'b0, 1'b0);
        apply("zero", 1'b0, 1'b0, 1'b1);

        walk("cw_detent", 1'b1, 3);
        walk("ccw_detent", 1'b0, 3);

        // Down from zero: wraps to 255 by default, holds at 0 when saturating.
        walk("ccw_from0", 1'b0, 1);

        apply("illegal", 1'b1, 1'b1, 1'b0);
        apply("after_ill", 1'b0, 1'b1, 1'b0);
        apply("wrap_up", 1'b0, 1'b0, 1'b0);

        // Count the detent instance to 7, then clear on the next counted edge.
        apply("zero2", 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) walk("to7", 1'b1, 1);
        check("at7 det.count", 32'(count_d), 32'd7);
        apply("pre_clr", 1'b1, 1'b0, 1'b0);
        apply("pre_clr", 1'b1, 1'b1, 1'b0);
        apply("pre_clr", 1'b0, 1'b1, 1'b0);
        apply("clr_step", 1'b0, 1'b0, 1'b1);
        check("clr_step det.step",  32'(step_d),  32'd1);
        check("clr_step det.count", 32'(count_d), 32'd0);

        // Asynchronous reset while a step pulse is in flight.
        apply("pulse", 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        model_reset();
        #1;
        reset_n = 1'b1;
        apply("init10", 1'b1, 1'b0, 1'b0);
        apply("post_rst", 1'b1, 1'b1, 1'b0);
        apply("post_rst", 1'b0, 1'b1, 1'b0);
        apply("post_rst", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
